qosc_ctrl: RTL and testbench
============================

Name: qosc_ctrl

Overview:
Controller and sequencer for the 16-bit quadrature oscillator datapath.
- Accepts byte-serial configuration frames and holds the oscillator's coefficient, power and initial-value registers.
- Drives the oscillator's load line: holds it in load while idle, releases it on start.
- Decimates the running oscillator output and streams snapshots out as bytes over a valid/ready handshake.
- Sits between the chip's 8-bit I/O pins and the oscillator instance.

Parameters:
DIV_W, 16, width of the decimation register and counter.
LOAD_CYC, 2, number of cycles osc_load is held high in LOAD before RUN.

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_data  in  8  configuration byte
cfg_valid  in  1  cfg_data valid
cfg_ready  out  1  controller accepts cfg_data
start  in  1  single-cycle start request
stop  in  1  single-cycle stop request
re_coeff, im_coeff, power, accu_re_init, accu_im_init  out  16 each  registered oscillator configuration, signed
osc_load  out  1  oscillator load control
accu_re, accu_im  in  16 each  oscillator outputs, signed
out_data  out  8  sample byte
out_valid  out  1  out_data valid
out_ready  in  1  sink accepts out_data
running  out  1  high in LOAD or RUN
ovf  out  1  sticky sample-drop flag

Behaviour:
- Reset (async assert, sync release) sets these values:
  - re_coeff=16'h7FFF, im_coeff=0, power=16'h4000, accu_re_init=16'h4000, accu_im_init=0
  - div=0, state IDLE, osc_load=1, out_valid=0, out_data=0, ovf=0, running=0
  - cfg byte counter=0, serializer empty
- Config frame: 3 accepted bytes, in order ADDR, LO, HI.
  - A byte is accepted when cfg_valid && cfg_ready.
  - The target register updates on the cycle HI is accepted: {HI,LO}.
  - ADDR[2:0]: 0 re_coeff, 1 im_coeff, 2 power, 3 accu_re_init, 4 accu_im_init, 5 div (low DIV_W bits). ADDR[7:3] is ignored.
  - Addresses 6–7: the frame is consumed and discarded.
- cfg_ready=1 except in LOAD, where it is 0. A frame may straddle states; the byte counter is never reset by start or stop.
- Writes made in RUN take effect on the outputs immediately. Init registers only matter at the next LOAD.
- FSM:
  - IDLE: osc_load=1. start → LOAD, clears ovf.
  - LOAD: osc_load=1 for LOAD_CYC cycles (counter), then → RUN; the decimation counter is loaded with div.
  - RUN: osc_load=0. stop → IDLE; osc_load=1 from the next cycle. start is ignored.
  - stop in LOAD → IDLE. start and stop in the same cycle: stop wins. start in IDLE with stop high → stays IDLE.
- Decimation in RUN:
  - The counter decrements each cycle. At 0 it reloads div, and accu_re/accu_im are sampled that cycle, so the period is div+1 cycles.
  - First capture is div+1 cycles after entering RUN.
- Serializer (4-byte snapshot): order is re[7:0], re[15:8], im[7:0], im[15:8].
  - A capture when the serializer is empty loads the snapshot; out_valid rises on the next cycle.
  - out_valid stays high and out_data stays stable until out_ready. A byte transfers on out_valid && out_ready, and the next byte is presented on the following cycle (no bubbles required beyond that).
  - A capture while any snapshot byte is still pending: the capture is dropped, ovf sets (sticky until the next start), and the current snapshot continues unharmed.
  - A capture coinciding with the last byte's transfer is accepted (no overflow).
- Stop mid-serialization: the pending snapshot drains fully; no new captures occur.
- Reset mid-operation: all state returns to reset values immediately; any partial frame or snapshot is lost.

Decomposition:
- Package qosc_pkg:
  - FSM state enum (IDLE, LOAD, RUN)
  - register address constants (ADDR_RE … ADDR_DIV)
  - reset-value constants for the five configuration registers
- One sub-module, qosc_sample_ser, holds the snapshot register, byte index, valid/ready output logic and busy/accept signalling for ovf.
- Config decode and the FSM stay in qosc_ctrl.

Test Plan:
- Reset → register outputs 7FFF/0000/4000/4000/0000, osc_load=1, out_valid=0, cfg_ready=1.
- Frame 01,34,12 then 05,03,00 → im_coeff=16'h1234 on the HI-accept cycle, div=3. Frame 07,AA,BB → no register changes.
- start with div=3, accu_re=16'h1A2B, accu_im=16'hF00D held, out_ready=1:
  - osc_load high 2 cycles, then 0.
  - First capture 4 cycles into RUN; bytes 2B,1A,0D,F0.
  - Captures repeat every 4 cycles; ovf stays 0.
- div=0, out_ready=0 → first snapshot held on out_valid with out_data=2B stable; ovf=1 after the second capture. A subsequent start clears ovf.
- stop mid-snapshot after 2 bytes → remaining 2 bytes still delivered, osc_load=1, no further out_valid. Same-cycle start+stop in IDLE → stays IDLE.
- rst_n low mid-RUN with out_valid=1 → out_valid, running=0 and osc_load=1 asynchronously; config registers return to reset values.

Source files
------------

// File: rtl/qosc_pkg.sv
// Shared types and constants for the quadrature oscillator controller.
package qosc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic [2:0] ADDR_RE  = 3'd0;
    localparam logic [2:0] ADDR_IM  = 3'd1;
    localparam logic [2:0] ADDR_PWR = 3'd2;
    localparam logic [2:0] ADDR_ARE = 3'd3;
    localparam logic [2:0] ADDR_AIM = 3'd4;
    localparam logic [2:0] ADDR_DIV = 3'd5;

    localparam logic signed [15:0] RST_RE_COEFF = 16'sh7FFF;
    localparam logic signed [15:0] RST_IM_COEFF = 16'sh0000;
    localparam logic signed [15:0] RST_POWER    = 16'sh4000;
    localparam logic signed [15:0] RST_ACCU_RE  = 16'sh4000;
    localparam logic signed [15:0] RST_ACCU_IM  = 16'sh0000;

endpackage

// File: rtl/qosc_sample_ser.sv
// Snapshot register and byte serializer: re[7:0], re[15:8], im[7:0], im[15:8].
module qosc_sample_ser
    import qosc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cap_i,
    input  logic signed [15:0] re_i,
    input  logic signed [15:0] im_i,
    input  logic               out_ready_i,
    output logic [7:0]         out_data_o,
    output logic               out_valid_o,
    output logic               drop_o
);

    logic [31:0] snap_q;
    logic [1:0]  idx_q;
    logic        vld_q;
    logic        xfer;
    logic        last_xfer;
    logic        accept;

    // A capture is taken when empty or when the final byte leaves this cycle.
    always_comb begin
        xfer      = vld_q && out_ready_i;
        last_xfer = xfer && (idx_q == 2'd3);
        accept    = cap_i && (!vld_q || last_xfer);
        drop_o    = cap_i && !accept;
    end

    // Snapshot load, byte advance and valid tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_q <= '0;
            idx_q  <= '0;
            vld_q  <= 1'b0;
        end else if (accept) begin
            snap_q <= {im_i, re_i};
            idx_q  <= '0;
            vld_q  <= 1'b1;
        end else if (xfer) begin
            if (idx_q == 2'd3) begin
                idx_q <= '0;
                vld_q <= 1'b0;
            end else begin
                idx_q <= idx_q + 2'd1;
            end
        end
    end

    assign out_data_o  = snap_q[{idx_q, 3'b000} +: 8];
    assign out_valid_o = vld_q;

endmodule

// File: rtl/qosc_ctrl.sv
// Configuration decode, load/run sequencing and decimation for the oscillator.
module qosc_ctrl
    import qosc_pkg::*;
#(
    parameter int DIV_W    = 16,
    parameter int LOAD_CYC = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         cfg_data,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic               start,
    input  logic               stop,
    output logic signed [15:0] re_coeff,
    output logic signed [15:0] im_coeff,
    output logic signed [15:0] power,
    output logic signed [15:0] accu_re_init,
    output logic signed [15:0] accu_im_init,
    output logic               osc_load,
    input  logic signed [15:0] accu_re,
    input  logic signed [15:0] accu_im,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               running,
    output logic               ovf
);

    localparam int LC_W = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;

    state_e             state_q, state_d;
    logic [LC_W-1:0]    load_cnt_q;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   dec_q;
    logic [1:0]         cfg_cnt_q;
    logic [2:0]         addr_q;
    logic [7:0]         lo_q;
    logic signed [15:0] re_q, im_q, pwr_q, are_q, aim_q;
    logic               ovf_q;
    logic               start_go;
    logic               load_last;
    logic               capture;
    logic               drop;
    logic               cfg_acc;
    logic [15:0]        cfg_word;
    // Upper address bits carry no meaning.
    logic               unused_addr_hi;

    assign unused_addr_hi = ^cfg_data[7:3];
    assign load_last      = (load_cnt_q == LC_W'(LOAD_CYC - 1));
    assign capture        = (state_q == ST_RUN) && (dec_q == '0);
    assign cfg_acc        = cfg_valid && cfg_ready;
    assign cfg_word       = {cfg_data, lo_q};

    // Next state and state-derived outputs; stop always wins over start.
    always_comb begin
        state_d   = state_q;
        start_go  = 1'b0;
        osc_load  = 1'b1;
        running   = 1'b0;
        cfg_ready = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d  = ST_LOAD;
                    start_go = 1'b1;
                end
            end
            ST_LOAD: begin
                running   = 1'b1;
                cfg_ready = 1'b0;
                if (stop)           state_d = ST_IDLE;
                else if (load_last) state_d = ST_RUN;
            end
            ST_RUN: begin
                running  = 1'b1;
                osc_load = 1'b0;
                if (stop) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, load-phase counter, decimation counter and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            load_cnt_q <= '0;
            dec_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_LOAD) load_cnt_q <= load_cnt_q + LC_W'(1);
            else                    load_cnt_q <= '0;
            if (state_q == ST_LOAD && state_d == ST_RUN) dec_q <= div_q;
            else if (state_q == ST_RUN)                  dec_q <= capture ? div_q : dec_q - DIV_W'(1);
            if (start_go)  ovf_q <= 1'b0;
            else if (drop) ovf_q <= 1'b1;
        end
    end

    // Three-byte configuration frame: ADDR, LO, HI; register written on HI.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_cnt_q <= '0;
            addr_q    <= '0;
            lo_q      <= '0;
            re_q      <= RST_RE_COEFF;
            im_q      <= RST_IM_COEFF;
            pwr_q     <= RST_POWER;
            are_q     <= RST_ACCU_RE;
            aim_q     <= RST_ACCU_IM;
            div_q     <= '0;
        end else if (cfg_acc) begin
            case (cfg_cnt_q)
                2'd0: begin
                    addr_q    <= cfg_data[2:0];
                    cfg_cnt_q <= 2'd1;
                end
                2'd1: begin
                    lo_q      <= cfg_data;
                    cfg_cnt_q <= 2'd2;
                end
                default: begin
                    cfg_cnt_q <= 2'd0;
                    case (addr_q)
                        ADDR_RE:  re_q  <= cfg_word;
                        ADDR_IM:  im_q  <= cfg_word;
                        ADDR_PWR: pwr_q <= cfg_word;
                        ADDR_ARE: are_q <= cfg_word;
                        ADDR_AIM: aim_q <= cfg_word;
                        ADDR_DIV: div_q <= DIV_W'(cfg_word);
                        default:  ;
                    endcase
                end
            endcase
        end
    end

    assign re_coeff     = re_q;
    assign im_coeff     = im_q;
    assign power        = pwr_q;
    assign accu_re_init = are_q;
    assign accu_im_init = aim_q;
    assign ovf          = ovf_q;

    qosc_sample_ser u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .cap_i       (capture),
        .re_i        (accu_re),
        .im_i        (accu_im),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_valid_o (out_valid),
        .drop_o      (drop)
    );

endmodule

// File: tb/tb_qosc_ctrl.sv
// Directed bench for qosc_ctrl: config frames, sequencing, serializer and overflow.
module tb_qosc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  cfg_data = 8'h00;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] re_coeff, im_coeff, power, accu_re_init, accu_im_init;
    logic        osc_load;
    logic [15:0] accu_re = 16'h1A2B;
    logic [15:0] accu_im = 16'hF00D;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        running;
    logic        ovf;

    int n_checks = 0;
    int n_errors = 0;

    qosc_ctrl #(.DIV_W(16), .LOAD_CYC(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .start        (start),
        .stop         (stop),
        .re_coeff     (re_coeff),
        .im_coeff     (im_coeff),
        .power        (power),
        .accu_re_init (accu_re_init),
        .accu_im_init (accu_im_init),
        .osc_load     (osc_load),
        .accu_re      (accu_re),
        .accu_im      (accu_im),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .running      (running),
        .ovf          (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_byte(input logic [7:0] b);
        cfg_data  = b;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic check_regs(input string tag, input logic [15:0] exp_im);
        check({tag, "_re"},  {16'h0, re_coeff},     32'h7FFF);
        check({tag, "_im"},  {16'h0, im_coeff},     {16'h0, exp_im});
        check({tag, "_pwr"}, {16'h0, power},        32'h4000);
        check({tag, "_are"}, {16'h0, accu_re_init}, 32'h4000);
        check({tag, "_aim"}, {16'h0, accu_im_init}, 32'h0000);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check_regs("rst", 16'h0000);
        check("rst_load",  {31'h0, osc_load},  32'd1);
        check("rst_valid", {31'h0, out_valid}, 32'd0);
        check("rst_ready", {31'h0, cfg_ready}, 32'd1);
        check("rst_run",   {31'h0, running},   32'd0);
        check("rst_ovf",   {31'h0, ovf},       32'd0);
        check("rst_data",  {24'h0, out_data},  32'h00);
        rst_n = 1'b1;
        tick();

        // Config frames
        cfg_byte(8'h01);
        cfg_byte(8'h34);
        check("im_before_hi", {16'h0, im_coeff}, 32'h0000);
        cfg_byte(8'h12);
        check("im_on_hi", {16'h0, im_coeff}, 32'h1234);
        cfg_byte(8'h05);
        cfg_byte(8'h03);
        cfg_byte(8'h00);
        cfg_byte(8'h07);
        cfg_byte(8'hAA);
        cfg_byte(8'hBB);
        check_regs("addr7", 16'h1234);

        // Start with div=3, sink always ready
        start = 1'b1;
        tick();
        start = 1'b0;
        check("load0_osc",   {31'h0, osc_load},  32'd1);
        check("load0_run",   {31'h0, running},   32'd1);
        check("load0_ready", {31'h0, cfg_ready}, 32'd0);
        tick();
        check("load1_osc", {31'h0, osc_load}, 32'd1);
        tick();
        check("run0_osc",   {31'h0, osc_load},  32'd0);
        check("run0_ready", {31'h0, cfg_ready}, 32'd1);
        tick();
        tick();
        tick();
        check("run3_valid", {31'h0, out_valid}, 32'd0);
        tick();
        check("cap1_valid", {31'h0, out_valid}, 32'd1);
        check("cap1_b0",    {24'h0, out_data},  32'h2B);
        tick();
        check("cap1_b1", {24'h0, out_data}, 32'h1A);
        tick();
        check("cap1_b2", {24'h0, out_data}, 32'h0D);
        tick();
        check("cap1_b3", {24'h0, out_data}, 32'hF0);
        tick();
        check("cap2_valid", {31'h0, out_valid}, 32'd1);
        check("cap2_b0",    {24'h0, out_data},  32'h2B);
        check("cap2_ovf",   {31'h0, ovf},       32'd0);
        tick();
        check("cap2_b1", {24'h0, out_data}, 32'h1A);
        tick();
        check("cap2_b2", {24'h0, out_data}, 32'h0D);

        // Stop after two bytes of the second snapshot
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_osc",   {31'h0, osc_load},  32'd1);
        check("stop_run",   {31'h0, running},   32'd0);
        check("stop_valid", {31'h0, out_valid}, 32'd1);
        check("stop_b3",    {24'h0, out_data},  32'hF0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("stop_drained", {31'h0, out_valid}, 32'd0);
        end

        // Same-cycle start and stop in IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_run", {31'h0, running},  32'd0);
        check("ss_osc", {31'h0, osc_load}, 32'd1);

        // div=0 with a stalled sink
        cfg_byte(8'h05);
        cfg_byte(8'h00);
        cfg_byte(8'h00);
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("d0_run0_valid", {31'h0, out_valid}, 32'd0);
        tick();
        check("d0_valid", {31'h0, out_valid}, 32'd1);
        check("d0_b0",    {24'h0, out_data},  32'h2B);
        check("d0_ovf0",  {31'h0, ovf},       32'd0);
        tick();
        check("d0_ovf1", {31'h0, ovf}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("d0_hold", {24'h0, out_data}, 32'h2B);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("d0_idle_ovf", {31'h0, ovf}, 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_ovf", {31'h0, ovf}, 32'd0);
        tick();
        tick();
        tick();
        check("rerun_ovf",   {31'h0, ovf},       32'd1);
        check("rerun_valid", {31'h0, out_valid}, 32'd1);

        // Asynchronous reset in RUN
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'h0, out_valid}, 32'd0);
        check("arst_run",   {31'h0, running},   32'd0);
        check("arst_osc",   {31'h0, osc_load},  32'd1);
        check("arst_ovf",   {31'h0, ovf},       32'd0);
        check_regs("arst", 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
